fft_frame_scheduler: RTL and testbench
======================================

FFT_FRAME_SCHEDULER -- requirements
Module: fft_frame_scheduler

Interface
REQ-001 Parameter Q, default 15, sample MSB index; samples are Q+1 bits signed.
REQ-002 Parameter N, default 256, samples per frame; power of two.
REQ-003 Parameter LOG2N, default 8, log2(N); read/write pointer width.
REQ-004 clk  in  1  rising-edge clock; reset, synchronous, active-high; clock clk.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  one-cycle strobe, windowed sample present.
REQ-007 in_data  in  Q+1  signed windowed sample.
REQ-008 valid_request  in  1  one-cycle read request from FFT first stage.
REQ-009 valid_packet  out  1  level; complete frame ready for consumption.
REQ-010 valid_out  out  1  one-cycle strobe, data_out valid.
REQ-011 data_out  out  Q+1  signed sample returned to FFT stage.
REQ-012 frame_done  out  1  one-cycle pulse, frame fully served and bank released.
REQ-013 overflow  out  1  one-cycle pulse, incoming sample dropped.

Function
REQ-014 Storage SHALL be two banks of N samples (ping-pong); write side and read side SHALL operate independently and concurrently.
REQ-015 Write side: on in_valid with full[wr_bank]=0, store in_data at wr_ptr, increment wr_ptr; on write at wr_ptr=N-1 set full[wr_bank]=1, toggle wr_bank, wr_ptr=0.
REQ-016 On in_valid with full[wr_bank]=1, sample SHALL be dropped, wr_ptr unchanged, overflow pulsed the following cycle.
REQ-017 Read FSM states IDLE, ANNOUNCE, SERVE, RELEASE; encoding from package.
REQ-018 IDLE: if full[rd_bank]=1 go ANNOUNCE next cycle, else stay.
REQ-019 ANNOUNCE: valid_packet=1; on valid_request issue read of index 0, rd_cnt=1, go SERVE; valid_packet low from next cycle.
REQ-020 SERVE: each valid_request issues read of index rd_cnt, rd_cnt+1; when read N-1 is issued go RELEASE.
REQ-021 RELEASE (one cycle): clear full[rd_bank], toggle rd_bank, rd_cnt=0, frame_done=1, go IDLE.
REQ-022 valid_out SHALL assert exactly one cycle after each accepted valid_request with data_out = stored sample; back-to-back requests every cycle SHALL be supported.
REQ-023 valid_request in IDLE or RELEASE SHALL be ignored (no valid_out).
REQ-024 data_out SHALL hold its last value when valid_out=0.
REQ-025 Same-cycle in_valid to a bank cleared in RELEASE: clear has priority, sample accepted as index 0 of that bank's next frame; no overflow.
REQ-026 Frame completing on write side while read side serves the other bank: no interaction; that frame announced after RELEASE/IDLE.
REQ-027 Frames SHALL be served in write order; no frame served twice.

Reset
REQ-028 Reset SHALL force valid_packet, valid_out, data_out, frame_done, overflow to 0; full flags to 0; wr_bank, rd_bank, wr_ptr, rd_cnt to 0; FSM to IDLE.
REQ-029 Reset mid-frame SHALL discard all partial and pending frames; RAM contents not reset.

Configuration
REQ-030 With FFT_BIT_REVERSE_EN defined, read index SHALL be the LOG2N-bit bit-reversal of rd_cnt (decimation-in-time input order).
REQ-031 Without FFT_BIT_REVERSE_EN, read index SHALL equal rd_cnt (natural order).

Structure
REQ-032 Package fft_pkg SHALL hold Q, N, LOG2N defaults and read-FSM state encoding, shared with FFT stage blocks.
REQ-033 Storage SHALL be sub-module fft_pingpong_ram: 2N x (Q+1), one write port, one registered read port, bank select as address MSB.

Verification
REQ-034 Write 256 samples 0..255, request 256 back-to-back -> valid_packet high until first request; data_out 0..255 each one cycle after request; frame_done once.
REQ-035 Same with FFT_BIT_REVERSE_EN -> request 1 returns 128, request 2 returns 64, request 255 returns 255.
REQ-036 Write 3 full frames with no requests -> frames 1,2 stored, all 256 samples of frame 3 dropped with 256 overflow pulses; serving yields frames 1 then 2.
REQ-037 Requests spaced 3 cycles while writing next frame at 1 sample/cycle -> no overflow, both frames returned intact in order.
REQ-038 Reset after 100 requests of a frame -> all outputs 0, valid_packet 0; requests ignored until a new full frame written.
REQ-039 valid_request in IDLE with no frame stored -> no valid_out, state unchanged.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT defaults and read-FSM state encoding, common to the scheduler and the FFT stage blocks.
package fft_pkg;

    localparam int FFT_Q     = 15;
    localparam int FFT_N     = 256;
    localparam int FFT_LOG2N = 8;

    typedef enum logic [1:0] {
        RD_IDLE     = 2'd0,
        RD_ANNOUNCE = 2'd1,
        RD_SERVE    = 2'd2,
        RD_RELEASE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: bank select is the address MSB, one write port, one registered read port.
module fft_pingpong_ram #(
    parameter int W  = 16,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Only the read register is reset; it holds between reads so data_out stays stable.
    always_ff @(posedge clk) begin
        if (reset)      rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Ping-pong frame buffer between the windowing stage and the FFT first stage.
// Define FFT_BIT_REVERSE_EN to serve each frame in bit-reversed (DIT input) order.
module fft_frame_scheduler
    import fft_pkg::*;
#(
    parameter int Q     = FFT_Q,
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic signed [Q:0] in_data,
    input  logic              valid_request,
    output logic              valid_packet,
    output logic              valid_out,
    output logic signed [Q:0] data_out,
    output logic              frame_done,
    output logic              overflow
);

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    rd_state_e        state, state_next;
    logic [1:0]       full;
    logic             wr_bank, rd_bank;
    logic [LOG2N-1:0] wr_ptr, rd_cnt, rd_cnt_next, rd_idx;
    logic             rd_en, release_bank, wr_blocked, wr_en;

    assign release_bank = (state == RD_RELEASE);
    // A bank being released this cycle is already free for the incoming sample.
    assign wr_blocked   = full[wr_bank] && !(release_bank && (rd_bank == wr_bank));
    assign wr_en        = in_valid && !wr_blocked;

    always_ff @(posedge clk) begin
        if (reset) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= in_valid && wr_blocked;
            if (release_bank) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if (wr_en) begin
                if (wr_ptr == LAST) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_ptr        <= '0;
                end else begin
                    wr_ptr <= wr_ptr + LOG2N'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RD_IDLE;
            rd_cnt    <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_next;
            rd_cnt    <= rd_cnt_next;
            valid_out <= rd_en;
        end
    end

    always_comb begin
        state_next  = state;
        rd_cnt_next = rd_cnt;
        rd_en       = 1'b0;
        case (state)
            RD_IDLE: begin
                if (full[rd_bank]) state_next = RD_ANNOUNCE;
            end
            RD_ANNOUNCE: begin
                if (valid_request) begin
                    rd_en       = 1'b1;
                    rd_cnt_next = LOG2N'(1);
                    state_next  = RD_SERVE;
                end
            end
            RD_SERVE: begin
                if (valid_request) begin
                    rd_en       = 1'b1;
                    rd_cnt_next = rd_cnt + LOG2N'(1);
                    if (rd_cnt == LAST) state_next = RD_RELEASE;
                end
            end
            RD_RELEASE: begin
                rd_cnt_next = '0;
                state_next  = RD_IDLE;
            end
            default: state_next = RD_IDLE;
        endcase
    end

    assign valid_packet = (state == RD_ANNOUNCE);
    assign frame_done   = release_bank;

`ifdef FFT_BIT_REVERSE_EN
    for (genvar i = 0; i < LOG2N; i++) begin : g_rev
        assign rd_idx[i] = rd_cnt[LOG2N-1-i];
    end
`else
    assign rd_idx = rd_cnt;
`endif

    fft_pingpong_ram #(
        .W  (Q + 1),
        .AW (LOG2N + 1)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank, wr_ptr}),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr ({rd_bank, rd_idx}),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler: frames kept as plain arrays, read order from the index rule.
module tb_fft_frame_scheduler;

    localparam int Q     = 15;
    localparam int N     = 256;
    localparam int LOG2N = 8;

    typedef logic signed [Q:0] frame_t [N];

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic signed [Q:0] in_data = '0;
    logic              valid_request = 1'b0;
    logic              valid_packet, valid_out, frame_done, overflow;
    logic signed [Q:0] data_out;

    int checks = 0;
    int failures = 0;
    int ovf_cnt = 0;
    int fd_cnt = 0;

    always #5 clk = ~clk;

    fft_frame_scheduler #(.Q(Q), .N(N), .LOG2N(LOG2N)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .valid_request (valid_request),
        .valid_packet  (valid_packet),
        .valid_out     (valid_out),
        .data_out      (data_out),
        .frame_done    (frame_done),
        .overflow      (overflow)
    );

    always @(negedge clk) begin
        if (overflow === 1'b1)   ovf_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
    end

    // k-th request of a frame returns sample idx(k)
    function automatic int idx(input int k);
`ifdef FFT_BIT_REVERSE_EN
        int r = 0;
        for (int b = 0; b < LOG2N; b++)
            r = r | (((k >> b) & 1) << (LOG2N - 1 - b));
        return r;
`else
        return k;
`endif
    endfunction

    task automatic rand_frame(output frame_t f);
        for (int i = 0; i < N; i++) f[i] = (Q + 1)'($urandom());
    endtask

    // Drives one sample per cycle starting at the current negedge.
    task automatic write_frame(input frame_t f);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = f[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Issues cnt requests spaced gap cycles apart; returns on the negedge of the last data check.
    task automatic serve_frame(input frame_t f, input int gap, input int cnt, input string name);
        int t = 0;
        while (valid_packet !== 1'b1 && t < 600) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (valid_packet !== 1'b1) begin
            failures++;
            $display("FAIL %s_announce: valid_packet=%b expected 1", name, valid_packet);
        end
        for (int k = 0; k < cnt; k++) begin
            if (k > 0) begin
                for (int g = 1; g < gap; g++) begin
                    @(negedge clk);
                    checks++;
                    if (valid_out !== 1'b0) begin
                        failures++;
                        $display("FAIL %s_gap %0d: valid_out=%b expected 0", name, k, valid_out);
                    end
                end
            end
            valid_request = 1'b1;
            @(negedge clk);
            valid_request = 1'b0;
            checks++;
            if (valid_out !== 1'b1 || data_out !== f[idx(k)]) begin
                failures++;
                $display("FAIL %s_read %0d: valid_out=%b data_out=%0d expected valid_out=1 data_out=%0d",
                         name, k, valid_out, data_out, f[idx(k)]);
            end
            if (k == 0) begin
                checks++;
                if (valid_packet !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_packet_drop: valid_packet=%b expected 0", name, valid_packet);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid_packet, valid_out, frame_done, overflow} !== 4'b0 || data_out !== '0) begin
            failures++;
            $display("FAIL reset_state: pkt=%b vout=%b done=%b ovf=%b data=%0d expected all 0",
                     valid_packet, valid_out, frame_done, overflow, data_out);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_request();
        for (int i = 0; i < 5; i++) begin
            valid_request = 1'b1;
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b0 || valid_packet !== 1'b0) begin
                failures++;
                $display("FAIL idle_request %0d: valid_out=%b valid_packet=%b expected 0 0",
                         i, valid_out, valid_packet);
            end
        end
        valid_request = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp_frame();
        frame_t f;
        int fd0, o0;
        for (int i = 0; i < N; i++) f[i] = (Q + 1)'(i);
        fd0 = fd_cnt;
        o0  = ovf_cnt;
        write_frame(f);
        serve_frame(f, 1, N, "ramp");
        repeat (3) @(negedge clk);
        checks++;
        if (fd_cnt - fd0 != 1) begin
            failures++;
            $display("FAIL ramp_frame_done: pulses=%0d expected 1", fd_cnt - fd0);
        end
        checks++;
        if (ovf_cnt != o0) begin
            failures++;
            $display("FAIL ramp_overflow: pulses=%0d expected 0", ovf_cnt - o0);
        end
    endtask

    task automatic test_overflow();
        frame_t f1, f2, f3;
        int o0;
        rand_frame(f1);
        rand_frame(f2);
        rand_frame(f3);
        o0 = ovf_cnt;
        write_frame(f1);
        write_frame(f2);
        write_frame(f3);
        repeat (2) @(negedge clk);
        checks++;
        if (ovf_cnt - o0 != N) begin
            failures++;
            $display("FAIL overflow_count: pulses=%0d expected %0d", ovf_cnt - o0, N);
        end
        serve_frame(f1, 1, N, "ovf_f1");
        serve_frame(f2, 1, N, "ovf_f2");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (valid_packet !== 1'b0) begin
                failures++;
                $display("FAIL overflow_no_third %0d: valid_packet=%b expected 0", i, valid_packet);
            end
        end
    endtask

    // The first sample of fc lands exactly in the cycle fa's bank is released.
    task automatic test_release_priority();
        frame_t fa, fb, fc;
        int o0;
        rand_frame(fa);
        rand_frame(fb);
        rand_frame(fc);
        write_frame(fa);
        write_frame(fb);
        o0 = ovf_cnt;
        serve_frame(fa, 1, N, "rel_fa");
        write_frame(fc);
        repeat (2) @(negedge clk);
        checks++;
        if (ovf_cnt != o0) begin
            failures++;
            $display("FAIL release_priority_overflow: pulses=%0d expected 0", ovf_cnt - o0);
        end
        serve_frame(fb, 1, N, "rel_fb");
        serve_frame(fc, 1, N, "rel_fc");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_concurrent();
        frame_t fa, fb;
        int o0;
        rand_frame(fa);
        rand_frame(fb);
        write_frame(fa);
        o0 = ovf_cnt;
        fork
            serve_frame(fa, 3, N, "conc_fa");
            write_frame(fb);
        join
        repeat (2) @(negedge clk);
        checks++;
        if (ovf_cnt != o0) begin
            failures++;
            $display("FAIL concurrent_overflow: pulses=%0d expected 0", ovf_cnt - o0);
        end
        serve_frame(fb, 1, N, "conc_fb");
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        frame_t f, g;
        int fd0;
        rand_frame(f);
        for (int i = 0; i < N; i++) f[i][0] = 1'b1;
        rand_frame(g);
        write_frame(f);
        serve_frame(f, 1, 100, "mid");
        fd0 = fd_cnt;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid_packet, valid_out, frame_done, overflow} !== 4'b0 || data_out !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: pkt=%b vout=%b done=%b ovf=%b data=%0d expected all 0",
                     valid_packet, valid_out, frame_done, overflow, data_out);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            valid_request = 1'b1;
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b0 || valid_packet !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_ignore %0d: valid_out=%b valid_packet=%b expected 0 0",
                         i, valid_out, valid_packet);
            end
        end
        valid_request = 1'b0;
        checks++;
        if (fd_cnt != fd0) begin
            failures++;
            $display("FAIL reset_mid_frame_done: pulses=%0d expected 0", fd_cnt - fd0);
        end
        write_frame(g);
        serve_frame(g, 1, N, "post_reset");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_idle_request();
        test_ramp_frame();
        test_overflow();
        test_release_priority();
        test_concurrent();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
